fp_normalize_round: RTL and testbench
=====================================

FP_NORMALIZE_ROUND -- requirements
Module: fp_normalize_round

Interface
REQ-001 SHALL have parameter FLUSH_TO_ZERO, default 1: 1 = subnormal results flush to signed zero; 0 = subnormal results are encoded.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream adder result is present.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts input this cycle.
REQ-006 SHALL have port in_sign, input, 1 bit: sign of the raw sum.
REQ-007 SHALL have port in_exponent, input, 9 bits: unsigned biased exponent of the larger operand.
REQ-008 SHALL have port in_mantissa, input, 28 bits: [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky.
REQ-009 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port final_sum, output, 32 bits: IEEE-754 single-precision result.
REQ-012 SHALL have port overflow, output, 1 bit: result saturated to infinity.
REQ-013 SHALL have port underflow, output, 1 bit: result was subnormal or flushed.

Function
REQ-014 SHALL implement states IDLE, NORM, ROUND and DONE, with registered outputs.
REQ-015 SHALL drive in_ready=1 only in IDLE with rst low; an input is accepted on a rising edge where in_valid and in_ready are both 1, and all inputs are captured.
REQ-016 On accept with mantissa==0, SHALL set final_sum={in_sign,31'b0}, clear both flags, and go to DONE.
REQ-017 On accept with m[27]=1, SHALL shift m right by 1 with m[0] = old m[1] OR old m[0], increment exponent by 1, and go to ROUND.
REQ-018 On accept with m[27]=0 and m[26]=1, or with exponent<=1, SHALL go to ROUND; otherwise it SHALL go to NORM.
REQ-019 In NORM, each cycle SHALL shift m left by 1 (zero-filled) and decrement exponent by 1, and SHALL leave for ROUND once m[26]=1 or exponent==1.
REQ-020 In ROUND, SHALL round to nearest, ties to even, on G=m[2], R|S=m[1]|m[0], LSB=m[3]; round-up adds 8 to m.
REQ-021 In ROUND, a round-up that sets m[27] SHALL cause a right shift by 1 and an exponent increment by 1.
REQ-022 In ROUND with exponent>=255, SHALL set final_sum={sign,8'hFF,23'b0} and overflow=1.
REQ-023 In ROUND with m[26]=0 and FLUSH_TO_ZERO=1, SHALL set final_sum={sign,31'b0} and underflow=1.
REQ-024 In ROUND with m[26]=0 and FLUSH_TO_ZERO=0, SHALL set final_sum={sign,8'h00,m[25:3]} and underflow=1.
REQ-025 In ROUND for all other cases, SHALL set final_sum={sign,exp[7:0],m[25:3]} with both flags 0.
REQ-026 ROUND SHALL last exactly 1 cycle, then go to DONE.
REQ-027 Latency from the accept edge to out_valid high SHALL be 2+k cycles, where k is the number of NORM shifts; zero input SHALL take 1 cycle.
REQ-028 In DONE, SHALL hold out_valid=1 and keep final_sum and flags stable until out_ready=1, then return to IDLE with out_valid=0 on that edge.
REQ-029 in_ready SHALL be 0 in DONE, so no new input is accepted in the same cycle as an output handshake.
REQ-030 final_sum and the flags SHALL hold their value until the next ROUND or zero-capture updates them.

Reset
REQ-031 With rst high at a rising edge, SHALL set state=IDLE, out_valid=0, final_sum=0, overflow=0, underflow=0, and clear the internal mantissa and exponent.
REQ-032 in_ready SHALL be 0 while rst is high.
REQ-033 Reset in NORM, ROUND or DONE SHALL abort the operation with no output emitted; rst SHALL take priority over every handshake.

Verification
REQ-034 SHALL cover carry: sign 0, exp 127, m=28'h8000000 -> final_sum 32'h40000000, flags 0, out_valid 2 cycles after accept.
REQ-035 SHALL cover cancellation: sign 0, exp 127, m=28'h0000008 -> 23 NORM cycles, final_sum 32'h34000000, out_valid 25 cycles after accept.
REQ-036 SHALL cover rounding: exp 127, m=28'h4000004 -> 32'h3F800000 (tie, LSB even); m=28'h400000C -> 32'h3F800002; m=28'h7FFFFFC -> 32'h40000000 (rounding carry renormalized).
REQ-037 SHALL cover overflow: exp 254, m=28'h8000000 -> final_sum 32'h7F800000, overflow 1.
REQ-038 SHALL cover underflow and zero: exp 2, m=28'h1000000 -> FLUSH_TO_ZERO=1 gives 32'h00000000 with underflow 1, FLUSH_TO_ZERO=0 gives 32'h00400000 with underflow 1; sign 1, m=0 -> 32'h80000000, flags 0.
REQ-039 SHALL cover backpressure and reset: with out_ready held 0 for 5 cycles, out_valid, final_sum and flags stay stable and in_ready stays 0; rst pulsed mid-NORM gives out_valid 0 and in_ready 1 on the first cycle after rst deasserts, and a new input then completes correctly.

Source files
------------

// File: rtl/fp_normalize_round.sv
`default_nettype none
// ============================================================================
// Module      : fp_normalize_round
// Description : Post-add normalizer and round-to-nearest-even stage that
//               produces an IEEE-754 single-precision result with a
//               valid/ready handshake on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_normalize_round #(
    parameter int FLUSH_TO_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [8:0]  in_exponent,
    input  logic [27:0] in_mantissa,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] final_sum,
    output logic        overflow,
    output logic        underflow
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_norm  = 2'd1;
    localparam logic [1:0] c_round = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    logic [1:0]  r_state;
    logic        r_sign;
    logic [9:0]  r_exp;
    logic [27:0] r_mant;
    logic        r_out_valid;
    logic [31:0] r_final_sum;
    logic        r_overflow;
    logic        r_underflow;

    logic [1:0]  w_state_nxt;
    logic        w_sign_nxt;
    logic [9:0]  w_exp_nxt;
    logic [27:0] w_mant_nxt;
    logic        w_out_valid_nxt;
    logic [31:0] w_final_sum_nxt;
    logic        w_overflow_nxt;
    logic        w_underflow_nxt;

    logic        w_in_ready;
    logic        w_round_up;
    logic [24:0] w_mant_hi;
    logic        w_carry;
    logic        w_hidden_fin;
    logic [22:0] w_frac_fin;
    logic [9:0]  w_exp_fin;
    logic [27:0] w_mant_shl;
    logic [9:0]  w_exp_dec;

    assign w_in_ready = (r_state == c_idle) && !rst;

    // Rounding works on m[27:3]; m[27] is always clear on entry to ROUND,
    // so bit 24 of the sum is the rounding carry.
    assign w_round_up   = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
    assign w_mant_hi    = r_mant[27:3] + {24'd0, w_round_up};
    assign w_carry      = w_mant_hi[24];
    assign w_hidden_fin = w_mant_hi[24] | w_mant_hi[23];
    assign w_frac_fin   = w_carry ? w_mant_hi[23:1] : w_mant_hi[22:0];
    assign w_exp_fin    = w_carry ? r_exp + 10'd1 : r_exp;

    assign w_mant_shl   = {r_mant[26:0], 1'b0};
    assign w_exp_dec    = r_exp - 10'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_sign_nxt      = r_sign;
        w_exp_nxt       = r_exp;
        w_mant_nxt      = r_mant;
        w_out_valid_nxt = r_out_valid;
        w_final_sum_nxt = r_final_sum;
        w_overflow_nxt  = r_overflow;
        w_underflow_nxt = r_underflow;
        case (r_state)
            c_idle: begin
                if (in_valid && w_in_ready) begin
                    w_sign_nxt = in_sign;
                    w_exp_nxt  = {1'b0, in_exponent};
                    w_mant_nxt = in_mantissa;
                    if (in_mantissa == 28'd0) begin
                        w_final_sum_nxt = {in_sign, 31'd0};
                        w_overflow_nxt  = 1'b0;
                        w_underflow_nxt = 1'b0;
                        w_out_valid_nxt = 1'b1;
                        w_state_nxt     = c_done;
                    end else if (in_mantissa[27]) begin
                        // Keep the shifted-out bit alive in sticky.
                        w_mant_nxt  = {1'b0, in_mantissa[27:2], in_mantissa[1] | in_mantissa[0]};
                        w_exp_nxt   = {1'b0, in_exponent} + 10'd1;
                        w_state_nxt = c_round;
                    end else if (in_mantissa[26] || (in_exponent <= 9'd1)) begin
                        w_state_nxt = c_round;
                    end else begin
                        w_state_nxt = c_norm;
                    end
                end
            end
            c_norm: begin
                w_mant_nxt = w_mant_shl;
                w_exp_nxt  = w_exp_dec;
                if (w_mant_shl[26] || (w_exp_dec == 10'd1)) begin
                    w_state_nxt = c_round;
                end
            end
            c_round: begin
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = c_done;
                if (w_exp_fin >= 10'd255) begin
                    w_final_sum_nxt = {r_sign, 8'hFF, 23'd0};
                    w_overflow_nxt  = 1'b1;
                    w_underflow_nxt = 1'b0;
                end else if (!w_hidden_fin) begin
                    w_final_sum_nxt = (FLUSH_TO_ZERO != 0) ? {r_sign, 31'd0}
                                                           : {r_sign, 8'h00, w_frac_fin};
                    w_overflow_nxt  = 1'b0;
                    w_underflow_nxt = 1'b1;
                end else begin
                    w_final_sum_nxt = {r_sign, w_exp_fin[7:0], w_frac_fin};
                    w_overflow_nxt  = 1'b0;
                    w_underflow_nxt = 1'b0;
                end
            end
            c_done: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = c_idle;
                end
            end
            default: begin
                w_state_nxt     = c_idle;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_idle;
            r_sign      <= 1'b0;
            r_exp       <= 10'd0;
            r_mant      <= 28'd0;
            r_out_valid <= 1'b0;
            r_final_sum <= 32'd0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sign      <= w_sign_nxt;
            r_exp       <= w_exp_nxt;
            r_mant      <= w_mant_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_final_sum <= w_final_sum_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign final_sum = r_final_sum;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fp_normalize_round.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_normalize_round
// Description : Scoreboard bench for fp_normalize_round; a flush-to-zero and a
//               subnormal-encoding instance share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_normalize_round;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_sign;
    logic [8:0]  in_exponent;
    logic [27:0] in_mantissa;
    logic        out_ready;

    logic        in_ready,  in_ready_nf;
    logic        out_valid, out_valid_nf;
    logic [31:0] final_sum, final_sum_nf;
    logic        overflow,  overflow_nf;
    logic        underflow, underflow_nf;

    typedef struct {
        logic [31:0] sum_ftz;
        logic [31:0] sum_nf;
        logic        ovf;
        logic        unf;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle_cnt = 0;
    logic prev_valid = 1'b0;

    fp_normalize_round #(.FLUSH_TO_ZERO(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exponent(in_exponent), .in_mantissa(in_mantissa),
        .out_valid(out_valid), .out_ready(out_ready), .final_sum(final_sum),
        .overflow(overflow), .underflow(underflow)
    );

    fp_normalize_round #(.FLUSH_TO_ZERO(0)) dut_nf (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nf),
        .in_sign(in_sign), .in_exponent(in_exponent), .in_mantissa(in_mantissa),
        .out_valid(out_valid_nf), .out_ready(out_ready), .final_sum(final_sum_nf),
        .overflow(overflow_nf), .underflow(underflow_nf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: one scoreboard pop per rising out_valid.
    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            if (q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum_ftz",   final_sum,            e.sum_ftz);
                check("sum_nf",    final_sum_nf,         e.sum_nf);
                check("overflow",  {31'd0, overflow},    {31'd0, e.ovf});
                check("underflow", {31'd0, underflow},   {31'd0, e.unf});
                check("ovf_nf",    {31'd0, overflow_nf}, {31'd0, e.ovf});
                check("unf_nf",    {31'd0, underflow_nf},{31'd0, e.unf});
                check("latency_cycle", cycle_cnt, e.cyc);
                check("valid_nf",  {31'd0, out_valid_nf}, 32'd1);
            end
        end
        prev_valid = out_valid;
    end

    task automatic send(input logic s, input logic [8:0] e, input logic [27:0] m,
                        input logic [31:0] sf, input logic [31:0] sn,
                        input logic ov, input logic un, input int lat, input bit push);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'd0, 32'd1);
        end else begin
            in_sign     = s;
            in_exponent = e;
            in_mantissa = m;
            in_valid    = 1'b1;
            if (push) q.push_back('{sf, sn, ov, un, cycle_cnt + lat});
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0;
        in_exponent = 9'd0; in_mantissa = 28'd0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_final_sum", final_sum,          32'd0);
        check("rst_flags",     {30'd0, overflow, underflow}, 32'd0);
        rst = 1'b0;

        send(1'b0, 9'd127, 28'h8000000, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 2,  1'b1);
        send(1'b0, 9'd127, 28'h0000008, 32'h34000000, 32'h34000000, 1'b0, 1'b0, 25, 1'b1);
        send(1'b0, 9'd127, 28'h4000004, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 2,  1'b1);
        send(1'b0, 9'd127, 28'h400000C, 32'h3F800002, 32'h3F800002, 1'b0, 1'b0, 2,  1'b1);
        send(1'b0, 9'd127, 28'h7FFFFFC, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 2,  1'b1);
        send(1'b0, 9'd254, 28'h8000000, 32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 2,  1'b1);
        send(1'b0, 9'd2,   28'h1000000, 32'h00000000, 32'h00400000, 1'b0, 1'b1, 3,  1'b1);
        send(1'b1, 9'd100, 28'h0000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1,  1'b1);
        send(1'b1, 9'd130, 28'h4000000, 32'hC1000000, 32'hC1000000, 1'b0, 1'b0, 2,  1'b1);

        // Backpressure: result must hold while downstream stalls.
        begin
            int waited;
            waited = 0;
            while (!in_ready && waited < 100) begin @(negedge clk); waited++; end
            out_ready = 1'b0;
            send(1'b0, 9'd127, 28'h400000C, 32'h3F800002, 32'h3F800002, 1'b0, 1'b0, 2, 1'b1);
            waited = 0;
            while (!out_valid && waited < 50) begin @(negedge clk); waited++; end
            check("bp_reached_valid", {31'd0, out_valid}, 32'd1);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("bp_valid_hold", {31'd0, out_valid}, 32'd1);
                check("bp_sum_hold",   final_sum, 32'h3F800002);
                check("bp_flags_hold", {30'd0, overflow, underflow}, 32'd0);
                check("bp_in_ready",   {31'd0, in_ready}, 32'd0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            check("bp_release_valid", {31'd0, out_valid}, 32'd0);
            check("bp_release_ready", {31'd0, in_ready},  32'd1);
        end

        // Reset in the middle of a long normalization aborts it silently.
        send(1'b0, 9'd127, 28'h0000008, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_ready", {31'd0, in_ready},  32'd1);
        send(1'b0, 9'd127, 28'h0000008, 32'h34000000, 32'h34000000, 1'b0, 1'b0, 25, 1'b1);

        begin
            int waited;
            waited = 0;
            while (q.size() != 0 && waited < 200) begin @(negedge clk); waited++; end
            check("scoreboard_drained", q.size(), 32'd0);
            repeat (2) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
